plus_stream_checker: RTL and testbench

- Self-checking stimulus source and result reader for the registered 16-bit adder path (one-cycle-latency `a + b` unit).
- Drives pseudo-random operand pairs onto the adder's `a`/`b` inputs and reads back its sum output.
- Compares every returned sum against an internally pipelined expected value, then reports pass/fail, error count and first failing vector index.
- Sits beside the design under test in simulation and on-board bring-up builds.

---
 rtl/plus_stream_checker_if.sv | 39 +++
 rtl/plus_stream_checker.sv | 143 ++++++++++++++
 tb/tb_plus_stream_checker.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/plus_stream_checker_if.sv
// Signal bundle between the stream checker, the adder it exercises, and run control.
// The checker takes the master view; whoever drives start and returns sums takes the slave view.
interface plus_stream_checker_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [WIDTH-1:0] sum_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      err_count;
  logic [15:0]      first_err_idx;

  modport master (
    input  start,
    input  sum_in,
    output a_out,
    output b_out,
    output busy,
    output done,
    output pass,
    output err_count,
    output first_err_idx
  );

  modport slave (
    output start,
    output sum_in,
    input  a_out,
    input  b_out,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  first_err_idx
  );
endinterface

// File: rtl/plus_stream_checker.sv
// Drives LFSR operand pairs into a one-cycle registered adder and checks each returned sum
// against a two-stage expected pipeline, reporting pass, error count and first failing index.
module plus_stream_checker #(
  parameter int          WIDTH       = 16,
  parameter int          NUM_VECTORS = 256,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  plus_stream_checker_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    FLUSH,
    DONE
  } state_e;

  localparam logic [WIDTH-1:0] TAPS     = WIDTH'(16'hB400);
  localparam logic [WIDTH-1:0] A_SEED   = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] B_SEED   = WIDTH'(SEED ^ 16'hFFFF);
  localparam logic [15:0]      LAST_IDX = 16'(NUM_VECTORS - 1);
  localparam logic [15:0]      NUM_VEC  = 16'(NUM_VECTORS);

  state_e           state_q;
  logic [WIDTH-1:0] aOut_q;
  logic [WIDTH-1:0] bOut_q;
  logic [15:0]      vecIdx_q;
  logic             drvValid_q;
  logic             v1_q;
  logic [WIDTH-1:0] exp1_q;
  logic [15:0]      idx1_q;
  logic [15:0]      cmpCount_q;
  logic [15:0]      errCount_q;
  logic [15:0]      firstErrIdx_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic [WIDTH-1:0] aNext_d;
  logic [WIDTH-1:0] bNext_d;
  logic [WIDTH-1:0] expSum_d;
  logic             mismatch_d;
  logic [15:0]      errCountInc_d;

  // Galois LFSR steps, the modulo-2^WIDTH expected sum, and the saturating error increment.
  always_comb begin
    aNext_d       = (aOut_q >> 1) ^ (aOut_q[0] ? TAPS : '0);
    bNext_d       = (bOut_q >> 1) ^ (bOut_q[0] ? TAPS : '0);
    expSum_d      = aOut_q + bOut_q;
    mismatch_d    = v1_q && (bus.sum_in != exp1_q);
    errCountInc_d = (errCount_q == 16'hFFFF) ? errCount_q : errCount_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      aOut_q        <= '0;
      bOut_q        <= '0;
      vecIdx_q      <= '0;
      drvValid_q    <= 1'b0;
      v1_q          <= 1'b0;
      exp1_q        <= '0;
      idx1_q        <= '0;
      cmpCount_q    <= '0;
      errCount_q    <= '0;
      firstErrIdx_q <= 16'hFFFF;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      // The stage-1 register lines up with the adder's own output register.
      v1_q   <= drvValid_q;
      exp1_q <= expSum_d;
      idx1_q <= vecIdx_q;

      if (v1_q) begin
        cmpCount_q <= cmpCount_q + 16'd1;
        if (mismatch_d) begin
          errCount_q <= errCountInc_d;
          if (errCount_q == 16'd0) begin
            firstErrIdx_q <= idx1_q;
          end
        end
      end

      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            aOut_q        <= A_SEED;
            bOut_q        <= B_SEED;
            vecIdx_q      <= '0;
            drvValid_q    <= 1'b1;
            errCount_q    <= '0;
            firstErrIdx_q <= 16'hFFFF;
            cmpCount_q    <= '0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            state_q       <= DRIVE;
          end
        end
        DRIVE: begin
          if (vecIdx_q == LAST_IDX) begin
            drvValid_q <= 1'b0;
            state_q    <= FLUSH;
          end else begin
            aOut_q   <= aNext_d;
            bOut_q   <= bNext_d;
            vecIdx_q <= vecIdx_q + 16'd1;
          end
        end
        FLUSH: begin
          // No compare can land on this edge, so errCount_q is already final.
          if (cmpCount_q == NUM_VEC) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (errCount_q == 16'd0);
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      seedLegal: assert (SEED != 16'h0000 && SEED != 16'hFFFF);
      numVectorsLegal: assert (NUM_VECTORS >= 1 && NUM_VECTORS <= 65535);
    end
  end

  assign bus.a_out         = aOut_q;
  assign bus.b_out         = bOut_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = errCount_q;
  assign bus.first_err_idx = firstErrIdx_q;

endmodule

// File: tb/tb_plus_stream_checker.sv
// Bench for plus_stream_checker: a registered adder model with fault modes feeds the checker,
// and a done-triggered monitor pops the expected run results queued by the stimulus.
module tb_plus_stream_checker;

  localparam int WIDTH       = 16;
  localparam int NUM_VECTORS = 256;
  localparam int RUN_LATENCY = NUM_VECTORS + 2;

  typedef enum int {
    ADD_OK,
    ADD_FLIP5,
    ADD_STUCK0
  } add_mode_e;

  typedef struct {
    logic        passV;
    logic [15:0] errV;
    logic [15:0] firstV;
    int          latV;
    string       tag;
  } exp_t;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  add_mode_e addMode = ADD_OK;
  int        edgeCnt;
  int        checks = 0;
  int        errors = 0;
  exp_t      expQ[$];

  always #5 clk = ~clk;

  plus_stream_checker_if #(.WIDTH(WIDTH)) bus ();

  plus_stream_checker #(
    .WIDTH(WIDTH),
    .NUM_VECTORS(NUM_VECTORS),
    .SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Registered adder model; edgeCnt is the old count at edge e, so vector e-1 is being captured.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sum_in <= '0;
      edgeCnt    <= 0;
    end else begin
      if (bus.start && !bus.busy) edgeCnt <= 0;
      else                        edgeCnt <= edgeCnt + 1;
      case (addMode)
        ADD_STUCK0: bus.sum_in <= '0;
        ADD_FLIP5:  bus.sum_in <= (bus.a_out + bus.b_out) ^ ((edgeCnt == 5) ? 16'h0001 : 16'h0000);
        default:    bus.sum_in <= bus.a_out + bus.b_out;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".a_out"}, 32'(bus.a_out), 32'h0);
    checkOutput({tag, ".b_out"}, 32'(bus.b_out), 32'h0);
    checkOutput({tag, ".busy"}, 32'(bus.busy), 32'h0);
    checkOutput({tag, ".done"}, 32'(bus.done), 32'h0);
    checkOutput({tag, ".pass"}, 32'(bus.pass), 32'h0);
    checkOutput({tag, ".err_count"}, 32'(bus.err_count), 32'h0);
    checkOutput({tag, ".first_err_idx"}, 32'(bus.first_err_idx), 32'hFFFF);
  endtask

  // Queues the expected run result, pulses start, and checks the first two vectors.
  task automatic applyStimulus(input string tag, input add_mode_e mode, input logic doPush,
                               input logic expPass, input logic [15:0] expErr, input logic [15:0] expFirst);
    exp_t e;
    addMode = mode;
    if (doPush) begin
      e.passV  = expPass;
      e.errV   = expErr;
      e.firstV = expFirst;
      e.latV   = RUN_LATENCY;
      e.tag    = tag;
      expQ.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput({tag, ".vec0_a"}, 32'(bus.a_out), 32'hACE1);
    checkOutput({tag, ".vec0_b"}, 32'(bus.b_out), 32'h531E);
    checkOutput({tag, ".busy_after_start"}, 32'(bus.busy), 32'h1);
    checkOutput({tag, ".done_cleared"}, 32'(bus.done), 32'h0);
    checkOutput({tag, ".err_cleared"}, 32'(bus.err_count), 32'h0);
    checkOutput({tag, ".first_cleared"}, 32'(bus.first_err_idx), 32'hFFFF);
    @(negedge clk);
    checkOutput({tag, ".vec1_a"}, 32'(bus.a_out), 32'hE270);
    checkOutput({tag, ".vec1_b"}, 32'(bus.b_out), 32'h298F);
    if (mode == ADD_OK) checkOutput({tag, ".sum_vec0"}, 32'(bus.sum_in), 32'hFFFF);
    @(negedge clk);
    // E270 + 298F = 1_0BFF; the adder returns only the low 16 bits.
    if (mode == ADD_OK) checkOutput({tag, ".sum_vec1_wrap"}, 32'(bus.sum_in), 32'h0BFF);
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (!bus.done && n < RUN_LATENCY + 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, ".done_within_bound"}, 32'(bus.done), 32'h1);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: on each rising done, pop the queued expectation and compare the run summary.
  initial begin : monitor
    logic donePrev;
    exp_t e;
    donePrev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done && !donePrev) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 32'(bus.done), 32'h0);
        end else begin
          e = expQ.pop_front();
          checkOutput({e.tag, ".pass"}, 32'(bus.pass), 32'(e.passV));
          checkOutput({e.tag, ".err_count"}, 32'(bus.err_count), 32'(e.errV));
          checkOutput({e.tag, ".first_err_idx"}, 32'(bus.first_err_idx), 32'(e.firstV));
          checkOutput({e.tag, ".latency"}, 32'(edgeCnt), 32'(e.latV));
          checkOutput({e.tag, ".busy_at_done"}, 32'(bus.busy), 32'h0);
        end
      end
      donePrev = bus.done;
    end
  end

  initial begin : stimulus
    bus.start = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("por");
    rst_n = 1'b1;

    applyStimulus("clean", ADD_OK, 1'b1, 1'b1, 16'd0, 16'hFFFF);
    waitDone("clean");

    applyStimulus("flip5", ADD_FLIP5, 1'b1, 1'b0, 16'd1, 16'd5);
    waitDone("flip5");

    // Restart from DONE with a stray start while busy; the run must be unaffected.
    applyStimulus("restart", ADD_OK, 1'b1, 1'b1, 16'd0, 16'hFFFF);
    repeat (48) @(negedge clk);
    checkOutput("restart.busy_at_50", 32'(bus.busy), 32'h1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone("restart");

    applyStimulus("stuck0", ADD_STUCK0, 1'b1, 1'b0, 16'd256, 16'd0);
    waitDone("stuck0");

    applyStimulus("abort", ADD_OK, 1'b0, 1'b0, 16'd0, 16'hFFFF);
    repeat (98) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    @(negedge clk);
    checkResetValues("midreset_held");
    rst_n = 1'b1;

    applyStimulus("fresh", ADD_OK, 1'b1, 1'b1, 16'd0, 16'hFFFF);
    waitDone("fresh");

    checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
